pipe_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit: next generation of the team's combinational ripple adder.

---
 rtl/pipe_adder_pkg.sv | 9 +
 rtl/pipe_adder_if.sv | 23 ++
 rtl/pipe_adder_add_slice.sv | 17 +
 rtl/pipe_adder.sv | 81 ++++++++
 tb/tb_pipe_adder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// adder_pkg: shared constants and helpers for pipe_adder
// MODE_ADD/MODE_SUB select the operation; seg_count gives the number of pipeline stages
package adder_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction
endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder
// in_valid/in_ready/a/b/c_in/sub form the operand channel; out_valid/out_ready/sum/c_out the result channel
// ovf exists only when PIPE_ADDER_OVF_EN is defined
interface pipe_adder_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, c_in, sub;
  logic [WIDTH-1:0] a, b, sum;
  logic out_valid, out_ready, c_out;
`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
`endif
  modport master(output in_valid, a, b, c_in, sub, out_ready,
                 input in_ready, out_valid, sum, c_out
`ifdef PIPE_ADDER_OVF_EN
                 , input ovf
`endif
                 );
  modport slave(input in_valid, a, b, c_in, sub, out_ready,
                output in_ready, out_valid, sum, c_out
`ifdef PIPE_ADDER_OVF_EN
                , output ovf
`endif
                );
endinterface

// File: rtl/pipe_adder_add_slice.sv
// add_slice: combinational SEG-bit adder slice
// a, b, c_in -> sum, c_out; c_msb (carry into the slice MSB) only with PIPE_ADDER_OVF_EN
module add_slice #(parameter int SEG = 4) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] sum,
  output logic           c_out
`ifdef PIPE_ADDER_OVF_EN
  , output logic         c_msb
`endif
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};
`ifdef PIPE_ADDER_OVF_EN
  assign c_msb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];
`endif
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract, one SEG-bit carry slice per stage
// ports: clk, rst_n (async active-low), bus (pipe_adder_if.slave: operand and result handshakes)
// optional: PIPE_ADDER_OVF_EN adds a registered signed-overflow flag bus.ovf
module pipe_adder import adder_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic         clk,
  input logic         rst_n,
  pipe_adder_if.slave bus
);
  localparam int STAGES = seg_count(WIDTH, SEG);
  if (SEG > WIDTH || WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  // x carries finished sum slices below the current slice and untouched A bits above it;
  // y carries the (possibly inverted) B operand to the stages that still need it
  for (genvar k = 0; k < STAGES; k++) begin : g_s
    logic v, c, vi, ci, co;
    logic [WIDTH-1:0] x, xi, yi;
    logic [SEG-1:0] s;
`ifdef PIPE_ADDER_OVF_EN
    logic cm;
`endif
    if (k == 0) begin : g_in
      assign vi = bus.in_valid;
      assign ci = bus.sub == MODE_SUB ? 1'b1 : bus.c_in;
      assign xi = bus.a;
      assign yi = bus.sub == MODE_SUB ? ~bus.b : bus.b;
    end else begin : g_mid
      assign vi = g_s[k-1].v;
      assign ci = g_s[k-1].c;
      assign xi = g_s[k-1].x;
      assign yi = g_s[k-1].g_y.y;
    end
    add_slice #(.SEG(SEG)) u_slice (
      .a(xi[k*SEG +: SEG]),
      .b(yi[k*SEG +: SEG]),
      .c_in(ci),
      .sum(s),
      .c_out(co)
`ifdef PIPE_ADDER_OVF_EN
      , .c_msb(cm)
`endif
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        x <= '0;
      end else if (adv) begin
        v <= vi;
        c <= co;
        x <= xi;
        x[k*SEG +: SEG] <= s;
      end
    if (k < STAGES - 1) begin : g_y
      logic [WIDTH-1:0] y;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) y <= '0;
        else if (adv) y <= yi;
    end
`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf <= 1'b0;
        else if (adv) ovf <= cm ^ co;
    end
`endif
  end
  assign bus.out_valid = g_s[STAGES-1].v;
  assign bus.sum = g_s[STAGES-1].x;
  assign bus.c_out = g_s[STAGES-1].c;
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf = g_s[STAGES-1].g_ovf.ovf;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (WIDTH=16, SEG=4, latency 4)
module tb_pipe_adder;
  import adder_pkg::*;
  typedef struct packed {logic [15:0] s; logic co; logic ov;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pipe_adder_if #(.WIDTH(16)) bus();
  pipe_adder #(.WIDTH(16), .SEG(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  exp_t e_m;
  int cmp = 0, bad = 0, n_in = 0, n_out = 0;
  logic done;
  logic [15:0] ra, rb, held_sum;
  logic rc, rs;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
    logic [15:0] bb;
    logic [16:0] r;
    exp_t e;
    bb = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, bb} + {16'd0, sub ? 1'b1 : ci};
    e.s = r[15:0];
    e.co = r[16];
    e.ov = (a[15] == bb[15]) && (r[15] != a[15]);
    return e;
  endfunction
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL unexpected_out: got sum %h expected no beat", bus.sum);
      end else begin
        e_m = q.pop_front();
        chk("sum", {16'd0, bus.sum}, {16'd0, e_m.s});
        chk("c_out", {31'd0, bus.c_out}, {31'd0, e_m.co});
`ifdef PIPE_ADDER_OVF_EN
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e_m.ov});
`endif
      end
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tci, input logic ts, input exp_t e);
    bus.a = ta;
    bus.b = tb;
    bus.c_in = tci;
    bus.sub = ts;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        n_in++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    cmp++;
    bad++;
    $display("FAIL send_timeout: got in_ready 0 expected 1");
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.sub = MODE_ADD;
    bus.out_ready = 1'b1;
    tick(2);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_sum", {16'd0, bus.sum}, 0);
    chk("rst_c_out", {31'd0, bus.c_out}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    rst_n = 1'b1;
    tick(1);
    send(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b0});
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 4);
    tick(3);
    send(16'h0005, 16'h0007, 1'b0, MODE_SUB, '{16'hFFFE, 1'b0, 1'b0});
    send(16'h0007, 16'h0005, 1'b0, MODE_SUB, '{16'h0002, 1'b1, 1'b0});
    send(16'h0003, 16'h0003, 1'b1, MODE_SUB, '{16'h0000, 1'b1, 1'b0});
    tick(6);
    bus.out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b1, MODE_ADD, '{16'h2346, 1'b0, 1'b0});
    send(16'h8000, 16'h8000, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b1});
    send(16'h00FF, 16'h0F01, 1'b0, MODE_ADD, '{16'h1000, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 1'b1, MODE_SUB, '{16'h7FFF, 1'b1, 1'b1});
    held_sum = bus.sum;
    chk("fill_sum", {16'd0, held_sum}, 32'h2346);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 1);
      chk("stall_sum", {16'd0, bus.sum}, {16'd0, held_sum});
      chk("stall_c_out", {31'd0, bus.c_out}, 0);
    end
    tick(1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_valid", {31'd0, bus.out_valid}, (i < 4) ? 1 : 0);
    end
    tick(2);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("rand_drained", q.size(), 0);
    chk("rand_count", n_out, n_in);
    tick(1);
    send(16'h1111, 16'h2222, 1'b0, MODE_ADD, '{16'h3333, 1'b0, 1'b0});
    send(16'h4444, 16'h0004, 1'b0, MODE_SUB, '{16'h4440, 1'b1, 1'b0});
    send(16'h0001, 16'h0001, 1'b1, MODE_ADD, '{16'h0003, 1'b0, 1'b0});
    send(16'hF000, 16'h1000, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b0});
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_async_sum", {16'd0, bus.sum}, 0);
    q.delete();
    tick(2);
    rst_n = 1'b1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("no_stale", n, 0);
    tick(1);
    send(16'h0F0F, 16'h00F1, 1'b0, MODE_ADD, '{16'h1000, 1'b0, 1'b0});
`ifdef PIPE_ADDER_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0, MODE_ADD, '{16'h8000, 1'b0, 1'b1});
    send(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, '{16'h0000, 1'b1, 1'b0});
`endif
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("final_drained", q.size(), 0);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
